sccb_master: RTL and testbench
==============================

# sccb_master

SCCB (I2C-compatible) write-only master for the OV7670 camera configuration path. It accepts one register write per handshake from the configuration sequencer: a one-cycle start pulse with an 8-bit register address and 8-bit data. It then serialises a 3-phase SCCB write (device ID, sub-address, data) onto SIOC/SIOD. It sits between the configuration sequencer and the camera pads; the top level builds the SIOD tristate from `o_siod`/`o_siod_oe`.

## Interface
- `CLK_F`, 100_000_000, system clock frequency in Hz
- `SCCB_F`, 100_000, SIOC frequency in Hz; CLK_F must be divisible by 4*SCCB_F with quotient Q = CLK_F/(4*SCCB_F) >= 2
- `DEVICE_ID`, 8'h42, 8-bit SCCB write ID sent in phase 1
- `i_clk` in 1: single system clock, all logic on rising edge
- `i_rstn` in 1: asynchronous, active-low reset
- `i_start` in 1: write request, sampled only while idle
- `i_addr` in 8: register sub-address, latched on accept
- `i_data` in 8: register data, latched on accept
- `o_ready` out 1: high when idle and able to accept `i_start`
- `o_done` out 1: one-cycle pulse when a transaction completes
- `o_sioc` out 1: SCCB clock
- `o_siod` out 1: SCCB data value
- `o_siod_oe` out 1: 1 = drive `o_siod` onto the pad, 0 = release (pad pulled up)

## Operation
- **Reset** (async, immediate, including mid-transaction):
  - `o_ready`=1, `o_done`=0, `o_sioc`=1, `o_siod`=1, `o_siod_oe`=1.
  - State IDLE; divider and bit counters cleared; the bus is released to idle levels at once.
- **Quarter tick:** a divider counts 0..Q-1 and pulses a tick every Q cycles; it counts only outside IDLE. Every bus phase below lasts exactly one quarter (Q cycles).
- **IDLE:**
  - Outputs: `o_sioc`=1, `o_siod`=1, `o_siod_oe`=1, `o_ready`=1.
  - On `i_start`=1: latch the shift word {DEVICE_ID, i_addr, i_data}, go to START, and drive `o_ready`<=0.
- **START, 2 quarters:**
  - q0: SIOC=1, SIOD=1.
  - q1: SIOC=1, SIOD=0 (start condition).
- **BITS, 27 slots:** 3 bytes x (8 data bits MSB first + 1 don't-care bit). Each slot has 4 quarters:
  - q0: SIOC=0, SIOD=bit.
  - q1: SIOC=0.
  - q2: SIOC=1.
  - q3: SIOC=1.
- **Don't-care slots** (slot index 8, 17, 26, counting from 0): `o_siod_oe`=0 and `o_siod`=1 for all 4 quarters. `o_siod_oe`=1 in every other state/slot.
- **STOP, 3 quarters:**
  - q0: SIOC=0, SIOD=0.
  - q1: SIOC=1, SIOD=0.
  - q2: SIOC=1, SIOD=1 (stop condition).
  - At the end of q2: go to IDLE, `o_ready`<=1, `o_done`<=1 for one cycle.
- **Busy requests:** `i_start` while not IDLE is ignored and never queued. `i_addr`/`i_data` changes after accept have no effect.
- **SIOD change rule:** SIOD changes only while SIOC=0, except the START and STOP edges.
- No ACK checking and no read support. The device ID LSB is sent exactly as given.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- `i_start` is sampled at edge T. `o_ready` is 0 from T+1 and SIOC/SIOD begin START q0 at T+1.
- A transaction is 2 + 27*4 + 3 = 113 quarters = 113*Q cycles. `o_ready` returns to 1, with `o_done`=1 for that single cycle, at cycle T+1+113*Q.
- Back-to-back writes: if `i_start` is asserted in the first cycle `o_ready`=1, the next START begins the following cycle. The bus spends at least one cycle at idle levels between the STOP and the next START.
- The sequencer's pattern (one-cycle start pulse, then re-checks ready two cycles later) sees `o_ready`=0, as required.

## Test plan
- **Reset values:** hold `i_rstn`=0 -> `o_ready`=1, `o_done`=0, `o_sioc`=1, `o_siod`=1, `o_siod_oe`=1. `i_start` pulses during reset are ignored.
- **Single write** (CLK_F=800, SCCB_F=100, Q=2): `i_start` with `i_addr`=8'h12, `i_data`=8'h80.
  - Sampling SIOD on SIOC rising edges gives bytes 8'h42, 8'h12, 8'h80.
  - `o_siod_oe`=0 during the 3 ninth-bit slots.
  - Start and stop conditions are present.
  - `o_ready` is low for exactly 226 cycles; `o_done` pulses once.
- **Busy ignore:** `i_start` with 8'h3A/8'h04 asserted 50 cycles into a transaction -> no effect on the bus; only the first write appears; exactly one `o_done`.
- **Back-to-back:** writes 8'h11/8'h01 then 8'h0C/8'h04, each issued on the first `o_ready`=1 cycle -> two complete, correctly decoded frames; one idle cycle between them; two `o_done` pulses.
- **Reset mid-transaction:** assert `i_rstn`=0 during the sub-address byte -> outputs go to idle values immediately. A write of 8'h40/8'hD0 issued after release completes correctly.
- **Protocol checker throughout:** SIOD never toggles while SIOC=1 except START and STOP, and SIOC high/low phases are each 2*Q cycles.

Source files
------------

// File: rtl/sccb_if.sv
// SCCB master handshake and pad-side signals, bundled so the sequencer,
// the master and the pad wrapper all agree on one set of names.
interface sccb_if;
  logic       i_start;
  logic [7:0] i_addr;
  logic [7:0] i_data;
  logic       o_ready;
  logic       o_done;
  logic       o_sioc;
  logic       o_siod;
  logic       o_siod_oe;

  // Side that serialises the write onto SIOC/SIOD
  modport master (
    input  i_start, i_addr, i_data,
    output o_ready, o_done, o_sioc, o_siod, o_siod_oe
  );

  // Configuration sequencer side
  modport slave (
    output i_start, i_addr, i_data,
    input  o_ready, o_done, o_sioc, o_siod, o_siod_oe
  );
endinterface

// File: rtl/sccb_master.sv
// SCCB (I2C-compatible) write-only master for the OV7670 configuration
// path. One accepted request produces a 3-phase write (ID, sub-address,
// data) framed by start/stop; every bus phase lasts one quarter of SIOC.
module sccb_master #(
  parameter int         CLK_F     = 100_000_000,
  parameter int         SCCB_F    = 100_000,
  parameter logic [7:0] DEVICE_ID = 8'h42
) (
  input  logic i_clk,
  input  logic i_rstn,
  sccb_if.master bus
);
  localparam int Q  = CLK_F / (4 * SCCB_F);
  localparam int CW = (Q > 1) ? $clog2(Q) : 1;

  typedef enum logic [1:0] {IDLE, START, BITS, STOP} state_t;

  state_t      state, nxt_state;
  logic [CW-1:0] cnt;
  logic [1:0]  qtr, nxt_qtr;     // quarter within the current phase/slot
  logic [3:0]  bitn, nxt_bitn;   // 0..7 data bits, 8 = don't-care slot
  logic [1:0]  byten, nxt_byten; // 0 = ID, 1 = sub-address, 2 = data
  logic [23:0] sreg, nxt_sreg;   // MSB is the bit currently on the wire
  logic        tick;
  logic        n_sioc, n_siod, n_oe;

  assign tick = (cnt == CW'(Q - 1));

  // Position of the bus sequence after the current quarter ends
  always_comb begin
    nxt_state = state;
    nxt_qtr   = qtr + 2'd1;
    nxt_bitn  = bitn;
    nxt_byten = byten;
    nxt_sreg  = sreg;
    case (state)
      START: if (qtr == 2'd1) begin
        nxt_state = BITS;
        nxt_qtr   = 2'd0;
        nxt_bitn  = 4'd0;
        nxt_byten = 2'd0;
      end
      BITS: if (qtr == 2'd3) begin
        nxt_qtr = 2'd0;
        if (bitn == 4'd8) begin
          nxt_bitn = 4'd0;
          if (byten == 2'd2) nxt_state = STOP;
          else               nxt_byten = byten + 2'd1;
        end else begin
          // Only real data bits consume the shift word
          nxt_bitn = bitn + 4'd1;
          nxt_sreg = {sreg[22:0], 1'b0};
        end
      end
      STOP: if (qtr == 2'd2) begin
        nxt_state = IDLE;
        nxt_qtr   = 2'd0;
      end
      default: nxt_qtr = qtr;
    endcase
  end

  // Pad levels for the quarter being entered
  always_comb begin
    n_sioc = 1'b1;
    n_siod = 1'b1;
    n_oe   = 1'b1;
    case (nxt_state)
      START: n_siod = (nxt_qtr == 2'd0);
      BITS: begin
        n_sioc = nxt_qtr[1];
        if (nxt_bitn == 4'd8) n_oe   = 1'b0;
        else                  n_siod = nxt_sreg[23];
      end
      STOP: begin
        n_sioc = (nxt_qtr != 2'd0);
        n_siod = (nxt_qtr == 2'd2);
      end
      default: ;
    endcase
  end

  // Sequencer FSM: accept in IDLE, then step one quarter per divider tick
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state         <= IDLE;
      cnt           <= '0;
      qtr           <= 2'd0;
      bitn          <= 4'd0;
      byten         <= 2'd0;
      sreg          <= 24'd0;
      bus.o_ready   <= 1'b1;
      bus.o_done    <= 1'b0;
      bus.o_sioc    <= 1'b1;
      bus.o_siod    <= 1'b1;
      bus.o_siod_oe <= 1'b1;
    end else begin
      bus.o_done <= 1'b0;
      if (state == IDLE) begin
        cnt <= '0;
        if (bus.i_start) begin
          sreg          <= {DEVICE_ID, bus.i_addr, bus.i_data};
          state         <= START;
          qtr           <= 2'd0;
          bus.o_ready   <= 1'b0;
          // START q0 shares idle levels
          bus.o_sioc    <= 1'b1;
          bus.o_siod    <= 1'b1;
          bus.o_siod_oe <= 1'b1;
        end
      end else if (tick) begin
        cnt           <= '0;
        state         <= nxt_state;
        qtr           <= nxt_qtr;
        bitn          <= nxt_bitn;
        byten         <= nxt_byten;
        sreg          <= nxt_sreg;
        bus.o_sioc    <= n_sioc;
        bus.o_siod    <= n_siod;
        bus.o_siod_oe <= n_oe;
        if (nxt_state == IDLE) begin
          bus.o_ready <= 1'b1;
          bus.o_done  <= 1'b1;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sccb_master.sv
// Bench for sccb_master: directed writes, expected frames queued on issue,
// a bus monitor decodes SIOC/SIOD and compares on every o_done.
module tb_sccb_master;
  localparam int CLK_F  = 800;
  localparam int SCCB_F = 100;
  localparam int Q      = 2;
  localparam int TXN    = 113 * Q;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  sccb_if bus();

  sccb_master #(.CLK_F(CLK_F), .SCCB_F(SCCB_F), .DEVICE_ID(8'h42)) dut (
    .i_clk (clk),
    .i_rstn(rstn),
    .bus   (bus)
  );

  int vectors    = 0;
  int miscompares = 0;
  logic [26:0] exp_q[$];
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [26:0] frame(input logic [7:0] a, input logic [7:0] d);
    return {8'h42, 1'b1, a, 1'b1, d, 1'b1};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic        psioc = 1'b1, psiod = 1'b1;
  bit          in_frame = 0, have_frame = 0;
  int          nbits = 0, oe_bad = 0, ph_bad = 0, run = 0, ready_low = 0, idle_oe_bad = 0;
  logic [26:0] bits = '0, last_frame = '0, exp_f;

  always @(negedge clk) begin
    if (!rstn) begin
      in_frame   = 0;
      have_frame = 0;
      ready_low  = 0;
      run        = 0;
    end else begin
      if (bus.o_sioc && psioc && psiod && !bus.o_siod) begin
        if (in_frame) check("start_inside_frame", 1, 0);
        in_frame = 1; nbits = 0; bits = '0; oe_bad = 0; ph_bad = 0;
      end else if (bus.o_sioc && psioc && !psiod && bus.o_siod) begin
        if (!in_frame) check("stop_outside_frame", 1, 0);
        else begin
          last_frame = bits;
          have_frame = 1;
          check("bit_count", nbits, 27);
        end
        in_frame = 0;
      end
      if (!in_frame && !bus.o_siod_oe) idle_oe_bad++;
      if (in_frame && bus.o_sioc != psioc) begin
        if (bus.o_sioc) begin
          if (nbits < 27) begin
            if (run != 2 * Q) ph_bad++;
            bits = {bits[25:0], bus.o_siod};
            if (bus.o_siod_oe !== ((nbits % 9) != 8)) oe_bad++;
            nbits++;
          end else if (run != Q) ph_bad++;
        end else if (nbits > 0 && run != 2 * Q) ph_bad++;
      end
      if (bus.o_sioc != psioc) run = 1;
      else                     run++;
      if (!bus.o_ready) ready_low++;
      if (bus.o_done) begin
        done_cnt++;
        check("ready_low_cycles", ready_low, TXN);
        if (exp_q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          exp_f = exp_q.pop_front();
          check("frame_seen", {31'd0, have_frame}, 1);
          check("frame_bits", {5'd0, last_frame}, {5'd0, exp_f});
          check("ack_slot_oe", oe_bad, 0);
          check("phase_len", ph_bad, 0);
        end
        have_frame = 0;
      end
      if (bus.o_ready) ready_low = 0;
    end
    psioc = bus.o_sioc;
    psiod = bus.o_siod;
  end

  // ---------------- stimulus ----------------
  // Called at a negedge; returns at the following negedge
  task automatic issue(input logic [7:0] a, input logic [7:0] d, input bit expect_ok);
    bus.i_start = 1'b1;
    bus.i_addr  = a;
    bus.i_data  = d;
    if (expect_ok) exp_q.push_back(frame(a, d));
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_addr  = ~a;
    bus.i_data  = ~d;
  endtask

  task automatic wait_done();
    for (int i = 0; i < TXN + 20; i++) begin
      @(negedge clk);
      if (bus.o_done) return;
    end
    check("done_timeout", 0, 1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, bus.o_ready, 1);
    check({tag, "_done"}, bus.o_done, 0);
    check({tag, "_sioc"}, bus.o_sioc, 1);
    check({tag, "_siod"}, bus.o_siod, 1);
    check({tag, "_oe"}, bus.o_siod_oe, 1);
  endtask

  initial begin
    bus.i_start = 1'b0;
    bus.i_addr  = 8'h00;
    bus.i_data  = 8'h00;
    repeat (3) @(negedge clk);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    @(negedge clk);
    check_idle("reset");
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("ready_after_release", bus.o_ready, 1);

    // single write
    issue(8'h12, 8'h80, 1);
    check("ready_drop", bus.o_ready, 0);
    wait_done();
    repeat (3) @(negedge clk);

    // busy request mid-frame is dropped
    issue(8'h6B, 8'h4A, 1);
    repeat (48) @(negedge clk);
    issue(8'h3A, 8'h04, 0);
    wait_done();
    repeat (10) @(negedge clk);
    check("busy_done_count", done_cnt, 2);

    // back-to-back
    issue(8'h11, 8'h01, 1);
    wait_done();
    issue(8'h0C, 8'h04, 1);
    check("b2b_ready_drop", bus.o_ready, 0);
    wait_done();
    repeat (3) @(negedge clk);

    // reset during sub-address byte
    issue(8'h77, 8'h33, 0);
    repeat (100) @(negedge clk);
    #2 rstn = 1'b0;
    #1 check_idle("midreset");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    issue(8'h40, 8'hD0, 1);
    wait_done();
    repeat (20) @(negedge clk);

    check("done_total", done_cnt, 5);
    check("scoreboard_empty", exp_q.size(), 0);
    check("idle_oe", idle_oe_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
